// File: rtl/phys_reg_free_list_pkg.sv
// Shared sizing for the physical register free list, so rename, the RRAT
// and the free list agree on tag width, capacity and lane counts.
package phys_reg_free_list_pkg;

    localparam int NUM_PHYS_REGS = 64;
    localparam int NUM_ARCH_REGS = 32;
    localparam int INSTR_Q_WIDTH = 4;

    localparam int TAG_W         = $clog2(NUM_PHYS_REGS);
    localparam int ALLOC_WIDTH   = INSTR_Q_WIDTH;
    localparam int FREE_WIDTH    = 2 * INSTR_Q_WIDTH + 2;

    // Tags 0..NUM_ARCH_REGS (NZCV included) are mapped at reset, the rest are free.
    localparam int FREE_LIST_CAP = NUM_PHYS_REGS - NUM_ARCH_REGS - 1;

    typedef logic [TAG_W-1:0] phys_tag_t;

endpackage

// File: rtl/phys_reg_free_list_if.sv
// Bundle between rename/RRAT (master) and the free list (slave).
//
// Handshake: alloc_req is a per-lane request held by rename. alloc_grant is
// combinational. When it is high at a rising clock edge, every requesting
// lane has consumed the tag shown on alloc_tags. When it is low, nothing is
// consumed and rename must present the request again. free_valid lanes are
// unconditional strobes with no back-pressure. free_count, empty and
// overflow_err are registered status outputs.
interface phys_reg_free_list_if #(
    parameter int NUM_PHYS_REGS = phys_reg_free_list_pkg::NUM_PHYS_REGS,
    parameter int NUM_ARCH_REGS = phys_reg_free_list_pkg::NUM_ARCH_REGS,
    parameter int ALLOC_WIDTH   = phys_reg_free_list_pkg::ALLOC_WIDTH,
    parameter int FREE_WIDTH    = phys_reg_free_list_pkg::FREE_WIDTH
);
    localparam int TAG_W = $clog2(NUM_PHYS_REGS);
    localparam int CAP   = NUM_PHYS_REGS - NUM_ARCH_REGS - 1;
    localparam int CNT_W = $clog2(CAP + 1);

    logic [ALLOC_WIDTH-1:0]            alloc_req;
    logic                              alloc_grant;
    logic [ALLOC_WIDTH-1:0][TAG_W-1:0] alloc_tags;
    logic [FREE_WIDTH-1:0]             free_valid;
    logic [FREE_WIDTH-1:0][TAG_W-1:0]  free_tags;
    logic [CNT_W-1:0]                  free_count;
    logic                              empty;
    logic                              overflow_err;

    modport master (
        output alloc_req, free_valid, free_tags,
        input  alloc_grant, alloc_tags, free_count, empty, overflow_err
    );

    modport slave (
        input  alloc_req, free_valid, free_tags,
        output alloc_grant, alloc_tags, free_count, empty, overflow_err
    );

endinterface

// File: rtl/phys_reg_free_list_popcount_prefix.sv
// Exclusive prefix popcount: prefix[i] = number of set bits below bit i,
// and total = number of set bits overall. Used for lane compaction.
module popcount_prefix #(
    parameter int W  = 4,
    parameter int CW = $clog2(W + 1)
) (
    input  logic [W-1:0]         bits,
    output logic [W-1:0][CW-1:0] prefix,
    output logic [CW-1:0]        total
);

    logic [CW-1:0] acc;

    // Running sum across the lanes, captured before each lane adds itself.
    always_comb begin
        acc    = '0;
        prefix = '0;
        for (int i = 0; i < W; i++) begin
            prefix[i] = acc;
            acc       = acc + CW'(bits[i]);
        end
        total = acc;
    end

endmodule

// File: rtl/phys_reg_free_list.sv
// Circular free list of physical register tags. Rename allocates from the
// head all-or-nothing; the RRAT returns tags at the tail, compacted in lane
// order. A freed tag can be allocated from the next cycle onward.
module phys_reg_free_list
    import phys_reg_free_list_pkg::*;
#(
    parameter int NUM_PHYS_REGS = phys_reg_free_list_pkg::NUM_PHYS_REGS,
    parameter int NUM_ARCH_REGS = phys_reg_free_list_pkg::NUM_ARCH_REGS,
    parameter int ALLOC_WIDTH   = phys_reg_free_list_pkg::ALLOC_WIDTH,
    parameter int FREE_WIDTH    = phys_reg_free_list_pkg::FREE_WIDTH
) (
    input  logic           clk,
    input  logic           rst,
    phys_reg_free_list_if.slave bus
);

    localparam int TAG_W = $clog2(NUM_PHYS_REGS);
    localparam int CAP   = NUM_PHYS_REGS - NUM_ARCH_REGS - 1;
    localparam int CNT_W = $clog2(CAP + 1);
    localparam int PTR_W = $clog2(CAP);
    localparam int ACW   = $clog2(ALLOC_WIDTH + 1);
    localparam int FCW   = $clog2(FREE_WIDTH + 1);

    // Offsets never exceed the lane count, which is assumed <= CAP, so a
    // single compare-subtract is enough and CAP need not be a power of two.
    function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] base,
                                                  input int unsigned off);
        int unsigned s;
        s = int'(base) + off;
        if (s >= CAP) s = s - CAP;
        return PTR_W'(s);
    endfunction

    logic [TAG_W-1:0]             entry [CAP];
    logic [PTR_W-1:0]             head, tail;
    logic [CNT_W-1:0]             count;
    logic                         ovf;

    logic [ALLOC_WIDTH-1:0][ACW-1:0] a_prefix;
    logic [ACW-1:0]                  n_req;
    logic [FREE_WIDTH-1:0][FCW-1:0]  f_prefix;
    logic [FCW-1:0]                  n_free;

    logic                         grant;
    int unsigned                  cnt_after_alloc;
    logic                         free_ok;
    logic [CNT_W-1:0]             count_nxt;

    popcount_prefix #(.W(ALLOC_WIDTH), .CW(ACW)) u_alloc_pc (
        .bits   (bus.alloc_req),
        .prefix (a_prefix),
        .total  (n_req)
    );

    popcount_prefix #(.W(FREE_WIDTH), .CW(FCW)) u_free_pc (
        .bits   (bus.free_valid),
        .prefix (f_prefix),
        .total  (n_free)
    );

    // Grant decision uses the count before this cycle's frees; a batch that
    // would exceed capacity is a double-free and is dropped entirely.
    always_comb begin
        grant           = (int'(n_req) <= int'(count)) && !rst;
        cnt_after_alloc = int'(count) - (grant ? int'(n_req) : 0);
        free_ok         = (cnt_after_alloc + int'(n_free)) <= CAP;
        count_nxt       = free_ok ? CNT_W'(cnt_after_alloc + int'(n_free))
                                  : CNT_W'(cnt_after_alloc);
    end

    // Per-lane tag lookup from the head, compacted over requesting lanes.
    always_comb begin
        bus.alloc_tags = '0;
        for (int i = 0; i < ALLOC_WIDTH; i++) begin
            if (bus.alloc_req[i])
                bus.alloc_tags[i] = entry[wrap_add(head, int'(a_prefix[i]))];
        end
    end

    // Pointer, count, status and storage update.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < CAP; i++)
                entry[i] <= TAG_W'(NUM_ARCH_REGS + 1 + i);
            head  <= '0;
            tail  <= '0;
            count <= CNT_W'(CAP);
            ovf   <= 1'b0;
        end else begin
            if (grant)
                head <= wrap_add(head, int'(n_req));
            if (free_ok) begin
                for (int j = 0; j < FREE_WIDTH; j++) begin
                    if (bus.free_valid[j])
                        entry[wrap_add(tail, int'(f_prefix[j]))] <= bus.free_tags[j];
                end
                tail <= wrap_add(tail, int'(n_free));
            end else begin
                ovf <= 1'b1;
            end
            count <= count_nxt;
        end
    end

    assign bus.alloc_grant  = grant;
    assign bus.free_count   = count;
    assign bus.empty        = (count == '0);
    assign bus.overflow_err = ovf;

endmodule

// File: doc/phys_reg_free_list.md
Name: phys_reg_free_list

Overview:
Circular free list of physical register tags, shared by two requesters. Rename draws tags from it in order each cycle. The RRAT returns tags here when a committed instruction overwrites an older mapping. Sits between rename (consumer) and the RRAT free outputs (producer); it is the sole owner of unallocated physical registers.

Parameters:
NUM_PHYS_REGS, reg_pkg::NUM_PHYS_REGS, total physical registers; TAG_W = $clog2(NUM_PHYS_REGS)
NUM_ARCH_REGS, reg_pkg::NUM_ARCH_REGS, architectural GPRs; tags 0..NUM_ARCH_REGS (NZCV included) are mapped at reset
ALLOC_WIDTH, uop_pkg::INSTR_Q_WIDTH, rename allocation lanes per cycle
FREE_WIDTH, 2*uop_pkg::INSTR_Q_WIDTH+2, RRAT free lanes per cycle
CAP (localparam), NUM_PHYS_REGS-NUM_ARCH_REGS-1, list capacity

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
alloc_req  in  ALLOC_WIDTH  per-lane tag request from rename
alloc_grant  out  1  combinational; all requested lanes served this cycle
alloc_tags  out  ALLOC_WIDTH x TAG_W  combinational; tag per requesting lane
free_valid  in  FREE_WIDTH  per-lane free strobe from RRAT
free_tags  in  FREE_WIDTH x TAG_W  tags being returned
free_count  out  $clog2(CAP+1)  registered; current number of free tags
empty  out  1  registered; free_count==0
overflow_err  out  1  registered, sticky; a free would exceed CAP

Behaviour:
- Storage: CAP-entry array, head/tail pointers mod CAP, registered count.
- Reset: entries 0..CAP-1 = NUM_ARCH_REGS+1 .. NUM_PHYS_REGS-1; head=0; tail=0 (full); free_count=CAP; empty=0; overflow_err=0. Reset mid-operation discards all in-flight requests and frees. Outputs take reset values the cycle after rst is sampled.
- Allocation, all-or-nothing: n_req = popcount(alloc_req). alloc_grant = (n_req <= free_count) && !rst. n_req==0 gives grant=1 with no effect.
- Lane mapping: requesting lane i receives entry[(head + popcount(alloc_req[i-1:0])) mod CAP]. Tags on non-requesting lanes are don't-care but driven to 0.
- On posedge with grant: head += n_req (mod CAP). Denied requests consume nothing. Rename must re-present them; there is no queueing.
- Frees are compacted in lane order: valid lane j is written to entry[(tail + popcount(free_valid[j-1:0])) mod CAP]; tail += n_free.
- Free latency: a tag freed in cycle t becomes allocatable at cycle t+1, never in the same cycle.
- Same-cycle alloc and free: the grant decision uses free_count before the frees are added. Next count = free_count - (grant ? n_req : 0) + n_free.
- Overflow: if free_count - granted + n_free > CAP, set overflow_err. Drop the whole free batch: tail and count keep the post-allocation value. The condition reflects a double-free and is never legal.
- Wrap-around: pointer increments wrap modulo CAP; CAP need not be a power of two, so use compare-subtract, not bit truncation.
- No duplicate-tag checking beyond the overflow check.

Decomposition:
- reg_pkg: add FREE_LIST_CAP, phys_tag_t (logic [TAG_W-1:0]) and the free-lane width constant, so rename, RRAT and this block agree.
- Sub-module popcount_prefix (parameterized width): produces exclusive prefix counts plus the total. Instantiate once for alloc_req and once for free_valid.

Test Plan:
- Bench uses NUM_PHYS_REGS=64, NUM_ARCH_REGS=32, CAP=31, ALLOC_WIDTH=4, FREE_WIDTH=10.
- Reset: rst high 2 cycles, then low -> free_count=31, empty=0, overflow_err=0. alloc_req=4'b0101 -> grant=1, lane0=33, lane2=34; next cycle free_count=29, next alloc of 4'b0001 gives 35.
- Exhaustion: allocate 4 per cycle for 7 cycles (28 tags), then request 4 with count=3 -> grant=0, count stays 3. Request 3 -> grant=1, tags 61,62,63; empty=1 next cycle.
- Free and reuse: with empty=1, free lanes 1 and 7 carrying tags 40 and 12 -> same cycle alloc 4'b0001 denied. Next cycle count=2; alloc 4'b0011 -> lane0=40, lane1=12.
- Simultaneous alloc and free at count=1: request 2 and free 3 tags -> grant=0, next count=4. Request 1 and free 1 at count=4 -> grant=1, next count=4.
- Wrap and overflow: cycle head/tail past index 30 and check tag order is preserved across the wrap. At full (31), free 1 tag -> overflow_err=1 and stays set, free_count stays 31, until rst clears it.
